// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate width and frame-geometry helper
// for the timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam logic [COORD_W-1:0] COORD_ZERO = 10'd0;
    localparam logic [COORD_W-1:0] COORD_ONE  = 10'd1;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACT, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACT, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Per-axis counter bundle: step enable in, and the decoded position being
// loaded on the current edge (count/active/sync_n) plus the wrap strobe out.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic               step;
    logic [COORD_W-1:0] count;
    logic               wrap;
    logic               active;
    logic               sync_n;

    modport master (
        input  step,
        output count,
        output wrap,
        output active,
        output sync_n
    );

    modport slave (
        output step,
        input  count,
        input  wrap,
        input  active,
        input  sync_n
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (line or frame): a wrapping position counter with decode of
// the visible and sync windows for the position being loaded this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACT  = DEF_H_ACT,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_timing_if.master  axis
);

    localparam int TOTAL      = axis_total(ACT, FP, SYNC, BP);
    localparam int SYNC_START = ACT + FP;
    localparam int SYNC_END   = ACT + FP + SYNC;

    localparam logic [COORD_W-1:0] LAST_POS   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_LIM    = COORD_W'(ACT);
    localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SYNC_LIM   = COORD_W'(SYNC_END);

    logic [COORD_W-1:0] count_r;
    logic [COORD_W-1:0] nxt_count_s;
    logic               wrap_s;
    logic               nxt_active_s;
    logic               nxt_sync_n_s;

    // Next position and its window decode; the parent registers these so its
    // outputs describe exactly the position loaded on the same edge.
    always_comb begin
        wrap_s       = 1'b0;
        nxt_count_s  = count_r;
        nxt_active_s = 1'b0;
        nxt_sync_n_s = 1'b1;
        if (axis.step && (count_r == LAST_POS)) begin
            wrap_s      = 1'b1;
            nxt_count_s = COORD_ZERO;
        end else if (axis.step) begin
            nxt_count_s = count_r + COORD_ONE;
        end else begin
            nxt_count_s = count_r;
        end
        nxt_active_s = (nxt_count_s < ACT_LIM);
        nxt_sync_n_s = !((nxt_count_s >= SYNC_FIRST) && (nxt_count_s < SYNC_LIM));
    end

    // Position register; reset parks on the last position so the first
    // enabled edge after release lands on position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= LAST_POS;
        end else begin
            count_r <= nxt_count_s;
        end
    end

    assign axis.count  = nxt_count_s;
    assign axis.wrap   = wrap_s;
    assign axis.active = nxt_active_s;
    assign axis.sync_n = nxt_sync_n_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered coordinates, syncs, blanking and frame
// start. Optional build macro VGA_SYNC_DELAY_EN adds one stage to the control outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_N,
    output logic [COORD_W-1:0] oVGA_X,
    output logic [COORD_W-1:0] oVGA_Y,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK_N,
    output logic               oFRAME_START
);

    vga_timing_if h_axis ();
    vga_timing_if v_axis ();

    assign h_axis.step = 1'b1;
    assign v_axis.step = h_axis.wrap;

    vga_axis_counter #(
        .ACT  (H_ACT),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_axis (
        .clk   (iVGA_CLK),
        .rst_n (iRST_N),
        .axis  (h_axis)
    );

    vga_axis_counter #(
        .ACT  (V_ACT),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_axis (
        .clk   (iVGA_CLK),
        .rst_n (iRST_N),
        .axis  (v_axis)
    );

    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic               hs_r;
    logic               vs_r;
    logic               blank_n_r;
    logic               frame_start_r;

    // Output register; the frame wraps only when both axes wrap, which is
    // exactly the edge that loads pixel (0,0).
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_r           <= COORD_ZERO;
            y_r           <= COORD_ZERO;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_n_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            x_r           <= h_axis.active ? h_axis.count : COORD_ZERO;
            y_r           <= v_axis.active ? v_axis.count : COORD_ZERO;
            hs_r          <= h_axis.sync_n;
            vs_r          <= v_axis.sync_n;
            blank_n_r     <= h_axis.active && v_axis.active;
            frame_start_r <= v_axis.wrap;
        end
    end

    assign oVGA_X = x_r;
    assign oVGA_Y = y_r;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d_r;
    logic vs_d_r;
    logic blank_n_d_r;
    logic frame_start_d_r;

    // Extra control stage so syncs line up with the pattern stage's registered RGB.
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hs_d_r          <= 1'b1;
            vs_d_r          <= 1'b1;
            blank_n_d_r     <= 1'b0;
            frame_start_d_r <= 1'b0;
        end else begin
            hs_d_r          <= hs_r;
            vs_d_r          <= vs_r;
            blank_n_d_r     <= blank_n_r;
            frame_start_d_r <= frame_start_r;
        end
    end

    assign oVGA_HS      = hs_d_r;
    assign oVGA_VS      = vs_d_r;
    assign oVGA_BLANK_N = blank_n_d_r;
    assign oFRAME_START = frame_start_d_r;
`else
    assign oVGA_HS      = hs_r;
    assign oVGA_VS      = vs_r;
    assign oVGA_BLANK_N = blank_n_r;
    assign oFRAME_START = frame_start_r;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACT, default 640, SHALL set the number of visible pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL set the horizontal front porch length in clocks.
REQ-003 Parameter H_SYNC, default 96, SHALL set the horizontal sync pulse width in clocks.
REQ-004 Parameter H_BP, default 48, SHALL set the horizontal back porch length in clocks.
REQ-005 Parameter V_ACT, default 480, SHALL set the number of visible lines per frame.
REQ-006 Parameter V_FP, default 10, SHALL set the vertical front porch length in lines.
REQ-007 Parameter V_SYNC, default 2, SHALL set the vertical sync pulse width in lines.
REQ-008 Parameter V_BP, default 33, SHALL set the vertical back porch length in lines.
REQ-009 iVGA_CLK  input  1  SHALL be the pixel clock; all state SHALL update on its rising edge.
REQ-010 iRST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-011 oVGA_X  output  10  SHALL carry the active-area column consumed by the downstream pattern stage.
REQ-012 oVGA_Y  output  10  SHALL carry the active-area row.
REQ-013 oVGA_HS  output  1  SHALL be the horizontal sync, active-low.
REQ-014 oVGA_VS  output  1  SHALL be the vertical sync, active-low.
REQ-015 oVGA_BLANK_N  output  1  SHALL be high only inside the visible area.
REQ-016 oFRAME_START  output  1  SHALL be a one-clock pulse that marks pixel (0,0).

Function
REQ-017 H_TOTAL SHALL equal H_ACT+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal V_ACT+V_FP+V_SYNC+V_BP (default 525).
REQ-018 The horizontal counter h SHALL increment every clock and SHALL wrap from H_TOTAL-1 to 0.
REQ-019 The vertical counter v SHALL increment only on a clock where h wraps, and SHALL wrap from V_TOTAL-1 to 0 when h and v wrap on the same clock.
REQ-020 The line layout SHALL be: h 0..H_ACT-1 visible, then front porch, then sync (656..751 by default), then back porch; the frame layout SHALL follow the same order for v (sync at 490..491 by default).
REQ-021 All outputs SHALL be registered and SHALL describe the (h,v) value loaded on the same clock edge, giving zero latency relative to the counters.
REQ-022 oVGA_X SHALL equal h when h<H_ACT, else 0; oVGA_Y SHALL equal v when v<V_ACT, else 0.
REQ-023 oVGA_HS SHALL be 0 exactly while h is within the sync window; oVGA_VS SHALL be 0 exactly while v is within the sync window, and its edges SHALL coincide with h=0.
REQ-024 oVGA_BLANK_N SHALL be 1 if and only if h<H_ACT and v<V_ACT.
REQ-025 oFRAME_START SHALL be 1 if and only if h=0 and v=0, for exactly one clock per frame.

Reset
REQ-026 While iRST_N=0, h SHALL be H_TOTAL-1 and v SHALL be V_TOTAL-1, so that the first edge after release wraps both counters to (0,0) and pulses oFRAME_START.
REQ-027 While iRST_N=0, the outputs SHALL be oVGA_X=0, oVGA_Y=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0 and oFRAME_START=0.
REQ-028 Reset asserted mid-frame SHALL immediately force the REQ-026/027 state, with no partial-line completion.

Configuration
REQ-029 With VGA_SYNC_DELAY_EN defined, oVGA_HS, oVGA_VS, oVGA_BLANK_N and oFRAME_START SHALL be delayed by one extra register stage, while oVGA_X and oVGA_Y are not delayed, so that they align with the one-cycle registered RGB of the downstream pattern stage; the delay registers SHALL reset to the REQ-027 values.
REQ-030 Without VGA_SYNC_DELAY_EN, all outputs SHALL follow REQ-021 with zero added latency.

Structure
REQ-031 The default timing constants, H_TOTAL/V_TOTAL derivation and the 10-bit coordinate width SHALL reside in shared package vga_timing_pkg.
REQ-032 Each axis SHALL be built from one sub-module, vga_axis_counter (parameters: ACT, FP, SYNC, BP; inputs: step enable; outputs: count, wrap, active, sync_n), instantiated twice: horizontal with step enable=1, vertical with step enable=horizontal wrap.

Verification
REQ-033 Release reset, then 1 clock -> X=0, Y=0, BLANK_N=1, FRAME_START=1, HS=1, VS=1.
REQ-034 Run one line -> BLANK_N high for 640 clocks, HS low for 96 clocks starting at h=656, line period 800 clocks.
REQ-035 Run one frame -> FRAME_START period 420000 clocks, VS low for 1600 clocks starting at v=490/h=0, Y never exceeds 479.
REQ-036 Pulse iRST_N low at h=300, v=200 -> outputs at REQ-027 values during reset, and REQ-033 behaviour after release.
REQ-037 Build with VGA_SYNC_DELAY_EN -> HS, BLANK_N and FRAME_START each lag their non-delayed waveform by exactly 1 clock; X and Y are unchanged.
REQ-038 Override parameters to H 8/1/2/1 and V 4/1/1/1 -> line period 12, frame period 84, and counters wrap correctly.
